pipe_skid32: RTL and testbench
==============================

PIPE_SKID32 -- requirements
Module: pipe_skid32

Interface
REQ-001 Parameter: WIDTH, default 32, data-path width of both entries.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: in_valid  input  1  upstream stage presents in_data.
REQ-005 Port: in_ready  output  1  block can accept a word this cycle.
REQ-006 Port: in_data  input  WIDTH  upstream data word.
REQ-007 Port: out_valid  output  1  out_data holds a valid word.
REQ-008 Port: out_ready  input  1  downstream stage consumes out_data this cycle.
REQ-009 Port: out_data  output  WIDTH  head word, driven directly from the main register.
REQ-010 Port: flush  input  1  synchronous discard of all held words (branch/exception squash).
REQ-011 Port: occupancy  output  2  number of held words, 0..2.
REQ-012 Port: flush_drops  output  8  saturating count of words discarded by flush.

Function
REQ-013 The block SHALL hold two entries, main and skid, under a 3-state FSM: EMPTY (occupancy 0), ONE (1), FULL (2).
REQ-014 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from state only, with no combinational path from out_ready.
REQ-015 Accept = in_valid & in_ready; fire = out_valid & out_ready; out_valid SHALL be 1 exactly when state is not EMPTY.
REQ-016 EMPTY with accept: main <= in_data, go to ONE; without accept: stay EMPTY.
REQ-017 ONE with accept and fire: main <= in_data, stay ONE.
REQ-018 ONE with accept and no fire: skid <= in_data, go to FULL, main unchanged.
REQ-019 ONE with fire and no accept: go to EMPTY.
REQ-020 ONE with neither accept nor fire: hold state and main.
REQ-021 FULL with fire: main <= skid, go to ONE; without fire: hold both entries.
REQ-022 Latency: a word accepted into EMPTY SHALL appear on out_data with out_valid=1 in the next cycle.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-024 Words SHALL leave in acceptance order, with none lost or duplicated absent flush.
REQ-025 flush=1 SHALL force EMPTY at the next edge, overriding accept and fire in that cycle; a word presented with in_ready=1 during flush is discarded.
REQ-026 On flush, flush_drops SHALL add the pre-flush occupancy (0, 1 or 2), saturating at 255.
REQ-027 Entry contents after flush are don't-care, but out_valid SHALL be 0.
REQ-028 occupancy SHALL equal the state encoding: 0, 1 or 2.

Reset
REQ-029 reset=1 SHALL, at the next rising clk, set state EMPTY, main and skid to 0, and flush_drops to 0; reset overrides flush.
REQ-030 After reset: out_valid=0, out_data=0, in_ready=1, occupancy=0.
REQ-031 Reset asserted mid-transfer SHALL discard held words without counting them in flush_drops.

Verification
REQ-032 Reset, then in_valid=1, in_data=0x0000_00A5, out_ready=1 for 1 cycle -> next cycle out_valid=1, out_data=0x0000_00A5, occupancy=1.
REQ-033 out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0, out_data=0x11; then out_ready=1 for 2 cycles -> outputs 0x11, 0x22, then EMPTY.
REQ-034 Continuous in_valid=1 and out_ready=1 with an incrementing 1..100 stream -> 100 words out in order at one per cycle, occupancy never above 1.
REQ-035 FULL (0x33, 0x44) with flush=1 and in_valid=1 in the same cycle -> next cycle occupancy=0, out_valid=0, flush_drops=2, 0x33/0x44/new word never emitted.
REQ-036 Apply 130 flushes each at occupancy 2 -> flush_drops saturates at 255; then reset -> flush_drops=0, out_data=0.
REQ-037 Random valid/ready stimulus for 10k cycles with a scoreboard -> no loss, duplication or reordering; out_data stable under backpressure.

Source files
------------

// File: rtl/pipe_skid32.sv
// rtl/pipe_skid32.sv - two-entry skid buffer pipeline stage with flush
//
// Purpose: registered valid/ready stage holding up to two words (main + skid).
//   in_ready is decoded from state only, so there is no combinational path
//   from out_ready back to in_ready. flush squashes all held words and adds
//   the discarded count to a saturating counter.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   in_valid    in   upstream word present
//   in_ready    out  stage can accept a word this cycle
//   in_data     in   upstream word (WIDTH)
//   out_valid   out  out_data holds a valid word
//   out_ready   in   downstream consumes out_data this cycle
//   out_data    out  head word, straight from the main register (WIDTH)
//   flush       in   discard all held words
//   occupancy   out  held word count 0..2
//   flush_drops out  saturating count of words discarded by flush

module pipe_skid32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [7:0]       flush_drops
);

  // Encoding doubles as the occupancy value.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [7:0]       drops_q;
  logic [7:0]       drops_d;
  logic [8:0]       drops_sum;
  logic             accept;
  logic             fire;

  assign in_ready    = (state_q != ST_FULL);
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_data    = main_q;
  assign occupancy   = state_q;
  assign flush_drops = drops_q;

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  // One extra bit catches overflow so the counter can clamp at 255.
  assign drops_sum = {1'b0, drops_q} + {7'b0, state_q};
  assign drops_d   = drops_sum[8] ? 8'hFF : drops_sum[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      drops_q <= 8'd0;
    end else if (flush) begin
      // Entries are left as-is; out_valid drops with the state.
      state_q <= ST_EMPTY;
      drops_q <= drops_d;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_q  <= in_data;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && fire) begin
            main_q <= in_data;
          end else if (accept) begin
            skid_q  <= in_data;
            state_q <= ST_FULL;
          end else if (fire) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (fire) begin
            main_q  <= skid_q;
            state_q <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid32.sv
// tb/tb_pipe_skid32.sv - scoreboard testbench for pipe_skid32

module tb_pipe_skid32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        flush = 1'b0;
  logic [1:0]  occupancy;
  logic [7:0]  flush_drops;

  pipe_skid32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .flush       (flush),
    .occupancy   (occupancy),
    .flush_drops (flush_drops)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of words in flight, plus the drop counter.
  logic [31:0] sb[$];
  int          drops_m = 0;
  bit          zero_m = 1'b1;
  bit          mon_en = 1'b0;
  bit          mon_in_ready = 1'b1;
  int          fire_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares visible state against the model, then applies the
  // edge's effect on the model (reset, flush or a consumed head word).
  always @(negedge clk) begin
    int sz;
    if (mon_en) begin
      sz = sb.size();
      check("out_valid", {31'b0, out_valid}, (sz != 0) ? 32'd1 : 32'd0);
      check("in_ready", {31'b0, in_ready}, (sz < 2) ? 32'd1 : 32'd0);
      check("occupancy", {30'b0, occupancy}, sz);
      check("flush_drops", {24'b0, flush_drops}, drops_m);
      if (sz != 0) check("out_data", out_data, sb[0]);
      else if (zero_m) check("out_data_rst", out_data, 32'd0);
      mon_in_ready = (sz < 2);
      if (reset) begin
        sb.delete();
        drops_m = 0;
        zero_m = 1'b1;
      end else if (flush) begin
        drops_m = (drops_m + sz > 255) ? 255 : drops_m + sz;
        sb.delete();
        zero_m = 1'b0;
      end else if (sz != 0 && out_ready) begin
        void'(sb.pop_front());
        fire_cnt++;
      end
    end
  end

  // One clock of stimulus; the accepted word is pushed after the monitor
  // has used the pre-edge in_ready it expects.
  task automatic cycle(input bit v, input logic [31:0] d, input bit rdy,
                       input bit fl, input bit rst);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    reset     = rst;
    vectors++;
    @(negedge clk);
    #1;
    if (!rst && !fl && v && mon_in_ready) begin
      sb.push_back(d);
      zero_m = 1'b0;
    end
  endtask

  initial begin
    int f0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Single word latency
    cycle(1, 32'hA5, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("lat_out_data", out_data, 32'hA5);
    check("lat_occ", {30'b0, occupancy}, 32'd1);
    cycle(0, 0, 1, 0, 0);

    // Fill under backpressure, then drain
    cycle(1, 32'h11, 0, 0, 0);
    cycle(1, 32'h22, 0, 0, 0);
    cycle(1, 32'h99, 0, 0, 0);
    check("full_occ", {30'b0, occupancy}, 32'd2);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_head", out_data, 32'h11);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("drain_valid", {31'b0, out_valid}, 32'd0);

    // Streaming 1..100 at full rate
    f0 = fire_cnt;
    for (int i = 1; i <= 100; i++) begin
      cycle(1, i, 1, 0, 0);
      if (occupancy > 2'd1) check("stream_occ", {30'b0, occupancy}, 32'd1);
    end
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("stream_count", fire_cnt - f0, 32'd100);

    // Flush while full with a concurrent input word
    cycle(1, 32'h33, 0, 0, 0);
    cycle(1, 32'h44, 0, 0, 0);
    cycle(1, 32'h55, 1, 1, 0);
    cycle(0, 0, 1, 0, 0);
    check("flush_occ", {30'b0, occupancy}, 32'd0);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_cnt", {24'b0, flush_drops}, 32'd2);

    // Saturation
    for (int i = 0; i < 130; i++) begin
      cycle(1, $urandom, 0, 0, 0);
      cycle(1, $urandom, 0, 0, 0);
      cycle(0, 0, 0, 1, 0);
    end
    cycle(0, 0, 0, 0, 0);
    check("sat_cnt", {24'b0, flush_drops}, 32'd255);
    cycle(1, 32'h77, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    check("sat_rst_cnt", {24'b0, flush_drops}, 32'd0);
    check("sat_rst_data", out_data, 32'd0);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) == 0, $urandom_range(0, 499) == 0);
    end
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check("final_empty", {30'b0, occupancy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
